// File: rtl/rns_to_bin.sv
// rns_to_bin
// Converts a residue pair (X mod 256, X mod 129) back to the binary value X.
// It uses mixed-radix CRT: X = r256 + 256*k, where
// k = ((r129 - r256 mod 129) * 64) mod 129, and 64 is the inverse of 256 mod 129.
// The multiply by 64 is done as six modular doublings, one per clock, so every
// conversion takes exactly 8 edges from acceptance to result.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for a residue pair
// SUB   | reduce r256 mod 129, form k = (r129 - r256') mod 129
// DBL   | six modular doublings of k (k * 64 mod 129)
// FIN   | assemble dout = 256*k + r256, raise out_valid
// DONE  | hold result until out_valid && out_ready
module rns_to_bin #(
    parameter int CHECK_RANGE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  r256,
    input  logic [7:0]  r129,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] dout,
    output logic        out_err
);

    localparam logic [8:0] MOD = 9'd129;
    localparam logic [2:0] DBL_LAST = 3'd5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        DBL  = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] r256_q;
    logic [7:0] r129_q;
    logic [8:0] k;
    logic [2:0] cnt;

    logic [8:0] r256_red;
    logic [8:0] r129_red;
    logic [8:0] diff_raw;
    logic [8:0] diff_mod;
    logic [8:0] dbl_raw;
    logic [8:0] dbl_mod;
    logic       range_err;

    // Modular datapath: single conditional subtractions keep every value in 9 bits.
    always_comb begin
        r256_red  = {1'b0, r256_q};
        r129_red  = {1'b0, r129_q};
        diff_raw  = 9'd0;
        diff_mod  = 9'd0;
        dbl_raw   = 9'd0;
        dbl_mod   = 9'd0;
        range_err = 1'b0;

        if (r256_red >= MOD) begin
            r256_red = r256_red - MOD;
        end
        // Out-of-range r129 is reduced once; with range checking on the
        // result is replaced by the error value anyway.
        if (r129_red >= MOD) begin
            r129_red = r129_red - MOD;
        end

        // Both operands are below 129, so adding 129 first keeps it non-negative.
        diff_raw = r129_red + MOD - r256_red;
        diff_mod = (diff_raw >= MOD) ? (diff_raw - MOD) : diff_raw;

        dbl_raw = k << 1;
        dbl_mod = (dbl_raw >= MOD) ? (dbl_raw - MOD) : dbl_raw;

        range_err = (CHECK_RANGE != 0) && ({1'b0, r129_q} >= MOD);
    end

    // Sequencing FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            dout      <= 16'h0000;
            r256_q    <= 8'h00;
            r129_q    <= 8'h00;
            k         <= 9'd0;
            cnt       <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r256_q   <= r256;
                        r129_q   <= r129;
                        in_ready <= 1'b0;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    k     <= diff_mod;
                    cnt   <= 3'd0;
                    state <= DBL;
                end
                DBL: begin
                    k   <= dbl_mod;
                    cnt <= cnt + 3'd1;
                    if (cnt == DBL_LAST) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (range_err) begin
                        dout    <= 16'hFFFF;
                        out_err <= 1'b1;
                    end else begin
                        // k <= 128 in legal operation, so the sum stays below 33024.
                        dout    <= ({7'd0, k} << 8) + {8'h00, r256_q};
                        out_err <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rns_to_bin.sv
// tb_rns_to_bin
// Scoreboard bench for rns_to_bin: expected results are queued when a pair is
// driven and compared when out_valid appears.
module tb_rns_to_bin;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  r256;
    logic [7:0]  r129;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic        out_err;

    typedef struct {
        logic [15:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   n_err;
    int   n_chk;
    time  prev_acc;

    rns_to_bin #(.CHECK_RANGE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r256      (r256),
        .r129      (r129),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: search the 129 candidates X = a + 256*j for the one with X mod 129 == b.
    function automatic int ref_x(input int a, input int b);
        for (int j = 0; j < 129; j++) begin
            if ((a + 256 * j) % 129 == b) return a + 256 * j;
        end
        return -1;
    endfunction

    // Drive one pair, check latency and result, optionally stall the consumer.
    task automatic convert(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] ed, input logic ee,
                           input int hold, input bit chk_tp);
        int   n;
        time  t_acc;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk_val("in_ready_wait", 0, 1);
            return;
        end
        out_ready = (hold == 0);
        r256      = a;
        r129      = b;
        in_valid  = 1'b1;
        sb.push_back('{d: ed, e: ee});
        @(posedge clk);
        t_acc = $time;
        if (chk_tp) chk_val("throughput_ns", int'(t_acc - prev_acc), 100);
        prev_acc = t_acc;
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_val("latency", n, 8);
        e = sb.pop_front();
        chk_val("dout", dout, e.d);
        chk_val("out_err", out_err, e.e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            r256     = 8'($urandom_range(0, 255));
            r129     = 8'($urandom_range(0, 128));
            @(posedge clk);
            #1;
            chk_val("stall_dout", dout, e.d);
            chk_val("stall_valid", out_valid, 1);
            chk_val("stall_in_ready", in_ready, 0);
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_val("hs_out_valid", out_valid, 0);
        chk_val("hs_in_ready", in_ready, 1);
    endtask

    initial begin
        int  x;
        bit  seen;
        n_err     = 0;
        n_chk     = 0;
        prev_acc  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        r256      = 8'h00;
        r129      = 8'h00;

        #12;
        chk_val("rst_out_valid", out_valid, 0);
        chk_val("rst_out_err", out_err, 0);
        chk_val("rst_dout", dout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_val("rst_in_ready", in_ready, 1);

        // Back-to-back conversions with out_ready high: one result per 10 cycles.
        convert(8'd232, 8'd97, 16'(ref_x(232, 97)), 1'b0, 0, 1'b0);
        convert(8'd255, 8'd128, 16'd33023, 1'b0, 0, 1'b1);
        convert(8'd57, 8'd90, 16'd12345, 1'b0, 0, 1'b1);
        chk_val("ref_1000", ref_x(232, 97), 1000);

        convert(8'd0, 8'd0, 16'd0, 1'b0, 0, 1'b0);
        convert(8'd129, 8'd0, 16'd129, 1'b0, 0, 1'b0);
        convert(8'd17, 8'd200, 16'hFFFF, 1'b1, 0, 1'b0);
        convert(8'd57, 8'd90, 16'd12345, 1'b0, 5, 1'b0);

        // Reset in the middle of the doubling phase aborts the conversion.
        @(negedge clk);
        r256     = 8'd232;
        r129     = 8'd97;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_val("abort_out_valid", out_valid, 0);
        chk_val("abort_dout", dout, 0);
        chk_val("abort_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk_val("abort_no_valid", int'(seen), 0);
        convert(8'd232, 8'd97, 16'd1000, 1'b0, 0, 1'b0);

        // Strided sweep over the full range plus the top value.
        for (int i = 0; i < 33024; i += 37) begin
            convert(8'(i % 256), 8'(i % 129), 16'(i), 1'b0, 0, 1'b0);
        end
        x = 33023;
        convert(8'(x % 256), 8'(x % 129), 16'(x), 1'b0, 0, 1'b0);

        chk_val("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
